// File: rtl/apple2_disk_pkg.sv
// Shared constants for the Disk II track loader.
// State encoding and sector-address helper.
package apple2_disk_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int TRACK_BYTES  = 6656;
  localparam int DISK_TRACKS  = 35;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] NEXT = 2'd3;

  // Byte offset of a sector inside the track RAM
  function automatic logic [12:0] sec_base(
    input logic [3:0] s
  );
    return {s, 9'b0};
  endfunction

endpackage

// File: rtl/disk_track_loader.sv
// Disk II track loader: streams one track image
// from the SD block interface into the track RAM.
module disk_track_loader
  import apple2_disk_pkg::*;
#(
  parameter int          SECTORS_PER_TRACK = 13,
  parameter int          LAST_TRACK        = 34,
  parameter logic [31:0] LBA_BASE          = 32'd0
) (
  input  logic        CLK_14M,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  output logic        busy,
  output logic [5:0]  loaded_track
);

  localparam logic [5:0] LAST_T   = 6'(LAST_TRACK);
  localparam logic [3:0] SPT      = 4'(SECTORS_PER_TRACK);
  localparam logic [3:0] LAST_SEC = 4'(SECTORS_PER_TRACK - 1);
  localparam logic [5:0] NO_TRACK = 6'h3F;

  logic [1:0]  state_q, state_d;
  logic [3:0]  sec_q, sec_d;
  logic [5:0]  tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic [5:0]  ldt_q, ldt_d;
  logic        ack_q;
  logic [12:0] waddr_q;
  logic [7:0]  wdat_q;
  logic        we_q;

  logic [5:0]  eff_trk;
  logic [5:0]  cur_trk;
  logic        has_img;
  logic        trig;
  logic        ack_rise;
  logic        ack_fall;
  logic        req_entry;
  logic [9:0]  prod;

  // Clamp the head position and detect load triggers
  always_comb begin
    eff_trk  = (track > LAST_T) ? LAST_T : track;
    has_img  = |img_size;
    ack_rise = sd_ack & ~ack_q;
    ack_fall = ~sd_ack & ack_q;
    // While loading, compare against the track being fetched
    cur_trk  = busy_q ? tgt_q : ldt_q;
    trig     = has_img &
               (img_mounted | (eff_trk != cur_trk));
  end

  // Next-state logic for the load sequencer
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    tgt_d   = tgt_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    ldt_d   = ldt_q;
    pend_d  = pend_q | trig;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          tgt_d   = eff_trk;
          sec_d   = 4'd0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) state_d = NEXT;
      end
      NEXT: begin
        if (pend_q) begin
          tgt_d   = eff_trk;
          sec_d   = 4'd0;
          pend_d  = 1'b0;
          rd_d    = 1'b1;
          state_d = REQ;
        end else if (sec_q == LAST_SEC) begin
          ldt_d   = tgt_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sec_d   = sec_q + 4'd1;
          rd_d    = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!has_img) pend_d = 1'b0;
  end

  // Sector address, captured on every entry into REQ
  always_comb begin
    req_entry = (state_d == REQ) && (state_q != REQ);
    prod      = 10'(tgt_d) * 10'(SPT);
    lba_d     = lba_q;
    if (req_entry) begin
      lba_d = LBA_BASE + 32'(prod) + 32'(sec_d);
    end
  end

  // Sequencer state registers
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q   <= 4'd0;
      tgt_q   <= 6'd0;
      pend_q  <= 1'b0;
      lba_q   <= 32'd0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ldt_q   <= NO_TRACK;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      ldt_q   <= ldt_d;
    end
  end

  // One-cycle delay of sd_ack for edge detection
  always_ff @(posedge CLK_14M) begin
    ack_q <= sd_ack;
  end

  // Register each SD byte strobe into a RAM write
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      waddr_q <= 13'd0;
      wdat_q  <= 8'd0;
      we_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (state_q == XFER && sd_ack && sd_buff_wr) begin
        waddr_q <= sec_base(sec_q) + 13'(sd_buff_addr);
        wdat_q  <= sd_buff_dout;
        we_q    <= 1'b1;
      end
    end
  end

  assign sd_lba       = lba_q;
  assign sd_rd        = rd_q;
  assign ram_addr     = waddr_q;
  assign ram_di       = wdat_q;
  assign ram_we       = we_q;
  assign busy         = busy_q;
  assign loaded_track = ldt_q;

endmodule
